// File: rtl/sim_run_controller.sv
// rtl/sim_run_controller.sv - run sequencer: core reset warm-up, cycle/instruction counting, exit detection, log strobes
module sim_run_controller #(
  parameter int COMMIT_WIDTH = 6,
  parameter int RESET_CYCLES = 50,
  parameter int STUCK_LIMIT  = 2000,
  parameter int LOG_INTERVAL = 10000,
  parameter int CNT_W        = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [CNT_W-1:0]        max_instr,
  input  logic [CNT_W-1:0]        max_cycle,
  input  logic [COMMIT_WIDTH-1:0] commit_valid,
  input  logic                    commit_is_walk,
  input  logic                    trap_valid,
  input  logic                    trap_good,
  input  logic                    uart_query,
  output logic                    core_reset,
  output logic                    running,
  output logic                    done,
  output logic [2:0]              exit_code,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [CNT_W-1:0]        instr_count,
  output logic                    log_pulse,
  output logic                    uart_log_pulse
);

  localparam int HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int STUCK_W = $clog2(STUCK_LIMIT + 1);
  localparam int LOG_W   = $clog2(LOG_INTERVAL + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [STUCK_W-1:0] STUCK_LAST = STUCK_W'(STUCK_LIMIT);
  localparam logic [LOG_W-1:0]   LOG_RELOAD = LOG_W'(LOG_INTERVAL);

  localparam logic [2:0] EXIT_GOOD  = 3'd1;
  localparam logic [2:0] EXIT_BAD   = 3'd2;
  localparam logic [2:0] EXIT_STUCK = 3'd3;
  localparam logic [2:0] EXIT_INSTR = 3'd4;
  localparam logic [2:0] EXIT_CYCLE = 3'd5;

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [STUCK_W-1:0] stuck_timer;
  logic [LOG_W-1:0]   log_cnt;

  logic [CNT_W-1:0]   lane_sum;
  logic [CNT_W-1:0]   cycle_next;
  logic [CNT_W-1:0]   instr_next;
  logic [STUCK_W-1:0] stuck_next;
  logic               hit_stuck;
  logic               hit_instr;
  logic               hit_cycle;
  logic               log_hit;
  logic               exit_now;
  logic [2:0]         exit_sel;

  // Next-state values for one RUN cycle; the exit cycle's own updates are
  // what the exit conditions are judged against.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      lane_sum = lane_sum + CNT_W'(commit_valid[i]);
    end
    cycle_next = cycle_count + CNT_W'(1);
    instr_next = commit_is_walk ? instr_count : instr_count + lane_sum;
    stuck_next = (!commit_is_walk && commit_valid[0]) ? '0 : stuck_timer + STUCK_W'(1);

    hit_stuck = (stuck_next == STUCK_LAST);
    hit_instr = (max_instr != '0) && (instr_next >= max_instr);
    hit_cycle = (max_cycle != '0) && (cycle_next == max_cycle);
    log_hit   = (log_cnt == LOG_W'(1));

    exit_now = 1'b1;
    exit_sel = 3'd0;
    if (trap_valid) begin
      exit_sel = trap_good ? EXIT_GOOD : EXIT_BAD;
    end else if (hit_stuck) begin
      exit_sel = EXIT_STUCK;
    end else if (hit_instr) begin
      exit_sel = EXIT_INSTR;
    end else if (hit_cycle) begin
      exit_sel = EXIT_CYCLE;
    end else begin
      exit_now = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_HOLD;
      hold_cnt       <= '0;
      core_reset     <= 1'b1;
      running        <= 1'b0;
      done           <= 1'b0;
      exit_code      <= 3'd0;
      cycle_count    <= '0;
      instr_count    <= '0;
      stuck_timer    <= '0;
      log_cnt        <= LOG_RELOAD;
      log_pulse      <= 1'b0;
      uart_log_pulse <= 1'b0;
    end else begin
      log_pulse      <= 1'b0;
      uart_log_pulse <= 1'b0;
      case (state)
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state      <= S_RUN;
            core_reset <= 1'b0;
            running    <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        S_RUN: begin
          cycle_count    <= cycle_next;
          instr_count    <= instr_next;
          stuck_timer    <= stuck_next;
          log_cnt        <= log_hit ? LOG_RELOAD : log_cnt - LOG_W'(1);
          log_pulse      <= log_hit;
          uart_log_pulse <= uart_query;
          if (exit_now) begin
            state     <= S_DONE;
            running   <= 1'b0;
            done      <= 1'b1;
            exit_code <= exit_sel;
          end
        end
        S_DONE: begin
          // frozen until reset
        end
        default: begin
          state <= S_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sim_run_controller.sv
// tb/tb_sim_run_controller.sv - scoreboard bench for sim_run_controller
module tb_sim_run_controller;

  localparam int CW    = 6;
  localparam int CNT_W = 64;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [CNT_W-1:0] max_instr = '0;
  logic [CNT_W-1:0] max_cycle = '0;
  logic [CW-1:0]    commit_valid = '0;
  logic             commit_is_walk = 1'b0;
  logic             trap_valid = 1'b0;
  logic             trap_good = 1'b0;
  logic             uart_query = 1'b0;
  logic             core_reset;
  logic             running;
  logic             done;
  logic [2:0]       exit_code;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;
  logic             log_pulse;
  logic             uart_log_pulse;

  sim_run_controller #(
    .COMMIT_WIDTH(CW),
    .RESET_CYCLES(50),
    .STUCK_LIMIT (2000),
    .LOG_INTERVAL(10000),
    .CNT_W       (CNT_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .max_instr     (max_instr),
    .max_cycle     (max_cycle),
    .commit_valid  (commit_valid),
    .commit_is_walk(commit_is_walk),
    .trap_valid    (trap_valid),
    .trap_good     (trap_good),
    .uart_query    (uart_query),
    .core_reset    (core_reset),
    .running       (running),
    .done          (done),
    .exit_code     (exit_code),
    .cycle_count   (cycle_count),
    .instr_count   (instr_count),
    .log_pulse     (log_pulse),
    .uart_log_pulse(uart_log_pulse)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]       code;
    logic [CNT_W-1:0] instr;
    logic [CNT_W-1:0] cyc;
  } exp_t;

  exp_t             exp_q[$];
  logic [CNT_W-1:0] log_q[$];
  int               total = 0;
  int               bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Every edge passes through here so stray log strobes are always caught.
  task automatic tick();
    @(posedge clock);
    #1;
    if (log_pulse) begin
      if (log_q.size() == 0) check("log_extra", cycle_count, 0);
      else check("log_at", cycle_count, log_q.pop_front());
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_core_reset"}, core_reset, 1);
    check({tag, "_running"}, running, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_exit"}, exit_code, 0);
    check({tag, "_cycles"}, cycle_count, 0);
    check({tag, "_instrs"}, instr_count, 0);
    check({tag, "_log"}, log_pulse, 0);
    check({tag, "_uart"}, uart_log_pulse, 0);
  endtask

  task automatic reset_dut();
    commit_valid   = '0;
    commit_is_walk = 1'b0;
    trap_valid     = 1'b0;
    trap_good      = 1'b0;
    uart_query     = 1'b0;
    max_instr      = '0;
    max_cycle      = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic start_run();
    int n;
    reset_dut();
    check_reset_state("rst");
    n = 0;
    while (!running && n < 200) begin
      tick();
      n++;
    end
    check("hold_len", n, 50);
    check("hold_core_reset", core_reset, 0);
  endtask

  task automatic run_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      tick();
      check("early_done", done, 0);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int   n;
    exp_t e;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    if (!done) begin
      check({tag, "_timeout"}, 0, 1);
      return;
    end
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_exit"}, exit_code, e.code);
    check({tag, "_instrs"}, instr_count, e.instr);
    check({tag, "_cycles"}, cycle_count, e.cyc);
    check({tag, "_running"}, running, 0);
    check({tag, "_core_reset"}, core_reset, 0);
    // DONE must hold everything still even with live inputs
    commit_valid = '1;
    uart_query = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check({tag, "_frz_exit"}, exit_code, e.code);
    check({tag, "_frz_instrs"}, instr_count, e.instr);
    check({tag, "_frz_cycles"}, cycle_count, e.cyc);
    check({tag, "_frz_done"}, done, 1);
    check({tag, "_frz_uart"}, uart_log_pulse, 0);
    uart_query = 1'b0;
  endtask

  initial begin
    logic [CNT_W-1:0] m_instr;
    logic [CW-1:0]    cv;
    logic             wk;
    int               pulses;

    // Basic counting with mixed commit patterns and walk cycles
    start_run();
    m_instr = '0;
    for (int i = 1; i <= 8; i++) begin
      cv = CW'($urandom);
      wk = (i % 3 == 0);
      commit_valid = cv;
      commit_is_walk = wk;
      if (!wk) m_instr = m_instr + CNT_W'($countones(cv));
      tick();
      check("cnt_cycles", cycle_count, CNT_W'(i));
      check("cnt_instrs", instr_count, m_instr);
      check("cnt_running", running, 1);
    end

    // Instruction limit: 3 per cycle, limit 30 -> 10th RUN cycle; cycle limit ties but ranks lower
    start_run();
    commit_valid = 6'b000111;
    max_instr = 30;
    max_cycle = 10;
    exp_q.push_back('{3'd4, 64'd30, 64'd10});
    wait_done("instr", 100);

    // Reset from DONE
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("rst_done");

    // Walking commits never count and never clear the stuck timer
    start_run();
    commit_valid = 6'b000001;
    commit_is_walk = 1'b1;
    exp_q.push_back('{3'd3, 64'd0, 64'd2000});
    wait_done("stuck", 2100);

    // Good trap wins over simultaneous stuck and cycle limit
    start_run();
    max_cycle = 2000;
    run_cycles(1999);
    trap_valid = 1'b1;
    trap_good = 1'b1;
    exp_q.push_back('{3'd1, 64'd0, 64'd2000});
    wait_done("trap_good", 10);

    // Bad trap on the first RUN cycle
    start_run();
    trap_valid = 1'b1;
    trap_good = 1'b0;
    commit_valid = 6'b110011;
    exp_q.push_back('{3'd2, 64'd4, 64'd1});
    wait_done("trap_bad", 10);

    // Log strobes and cycle limit
    start_run();
    commit_valid = 6'b000001;
    max_cycle = 25000;
    log_q.push_back(64'd10000);
    log_q.push_back(64'd20000);
    exp_q.push_back('{3'd5, 64'd25000, 64'd25000});
    wait_done("cyc_lim", 26000);
    check("log_left", log_q.size(), 0);

    // uart strobes follow the level, then reset mid-RUN
    start_run();
    commit_valid = 6'b000001;
    uart_query = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      pulses += int'(uart_log_pulse);
    end
    uart_query = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      pulses += int'(uart_log_pulse);
    end
    check("uart_pulses", pulses, 3);
    check("uart_cycles", cycle_count, 6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("rst_run");
    tick();
    check("rehold_core_reset", core_reset, 1);
    check("rehold_running", running, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
